// File: rtl/hls_deadlock_monitor_gen2_pkg.sv
// Shared types and helpers for the HLS deadlock monitor: FSM state encoding,
// report-index width and the saturating counter increment.
package hls_deadlock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SUSPECT = 2'd1,
    BLOCKED = 2'd2
  } state_e;

  // Index width for an n-channel vector; never collapses to zero bits.
  function automatic int src_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Increment v, holding at the all-ones value of a w-bit counter.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
    logic [63:0] top;
    top = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v == top) ? v : v + 64'd1;
  endfunction

endpackage

// File: rtl/hls_deadlock_monitor_gen2_if.sv
// Monitor-side bundle: block/idle inputs from the HLS instance and the
// deadlock status and report outputs towards the monitor tree.
interface hls_deadlock_monitor_gen2_if
  import hls_deadlock_pkg::*;
#(
  parameter int NUM_AXIS = 5,
  parameter int NUM_SUB  = 4,
  parameter int CNT_W    = 16
) ();

  localparam int SUB_W = (NUM_SUB > 0) ? NUM_SUB : 1;
  localparam int SRC_W = src_w(NUM_AXIS + NUM_SUB);

  logic [NUM_AXIS-1:0] axis_block_sigs;
  logic [SUB_W-1:0]    sub_block_sigs;
  logic [SUB_W-1:0]    inst_idle_sigs;
  logic                clear;
  logic                block;
  logic                block_sticky;
  logic [SRC_W-1:0]    block_src;
  logic [CNT_W-1:0]    block_cycles;

  modport master (
    output axis_block_sigs, sub_block_sigs, inst_idle_sigs, clear,
    input  block, block_sticky, block_src, block_cycles
  );

  modport slave (
    input  axis_block_sigs, sub_block_sigs, inst_idle_sigs, clear,
    output block, block_sticky, block_src, block_cycles
  );

endinterface

// File: rtl/hls_deadlock_monitor_gen2_prio_enc.sv
// Lowest-set-index encoder used to record which channel started a
// blocking episode. Returns 0 when no bit is set.
module hls_deadlock_prio_enc
  import hls_deadlock_pkg::*;
#(
  parameter int W  = 8,
  parameter int OW = src_w(W)
) (
  input  logic [W-1:0]  vec,
  output logic [OW-1:0] idx
);

  // NOTE: combinational outputs get a default before any conditional
  // assignment so no path leaves them unassigned and infers a latch.
  always_comb begin
    idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) idx = OW'(i);
    end
  end

endmodule

// File: rtl/hls_deadlock_monitor_gen2.sv
// Deadlock monitor for one top-level HLS instance: qualifies stream and
// sub-instance block signals and asserts block after THRESHOLD persistent
// cycles. Define HLS_DEADLOCK_MON_REPORT_EN to build the source/duration report.
module hls_deadlock_monitor_gen2
  import hls_deadlock_pkg::*;
#(
  parameter int NUM_AXIS  = 5,
  parameter int NUM_SUB   = 4,
  parameter int THRESHOLD = 16,
  parameter int CNT_W     = 16
) (
  input logic                        clock,
  input logic                        reset,
  hls_deadlock_monitor_gen2_if.slave mon
);

  localparam int NQ     = NUM_AXIS + NUM_SUB;
  localparam int CNT_TW = (THRESHOLD > 1) ? $clog2(THRESHOLD) : 1;
  localparam logic [CNT_TW-1:0] CNT_LAST = CNT_TW'(THRESHOLD - 1);

  logic [NQ-1:0] q;
  logic          any_blk;

  // An idle sub-instance is masked so it can never count as blocked.
  generate
    if (NUM_SUB > 0) begin : g_sub
      assign q = {mon.sub_block_sigs & ~mon.inst_idle_sigs, mon.axis_block_sigs};
    end else begin : g_nosub
      logic unused_sub;
      assign unused_sub = ^{mon.sub_block_sigs, mon.inst_idle_sigs};
      assign q          = mon.axis_block_sigs;
    end
  endgenerate

  assign any_blk = |q;

  state_e              state_d, state_q;
  logic [CNT_TW-1:0]   cnt_d, cnt_q;
  logic                block_d, block_q;
  logic                sticky_d, sticky_q;
  logic                enter_blk, stay_blk;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (any_blk) begin
          if (THRESHOLD == 1) begin
            state_d = BLOCKED;
          end else begin
            state_d = SUSPECT;
            cnt_d   = CNT_TW'(1);
          end
        end
      end
      SUSPECT: begin
        if (!any_blk) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = BLOCKED;
        end else begin
          cnt_d = cnt_q + CNT_TW'(1);
        end
      end
      BLOCKED: begin
        if (!any_blk) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign enter_blk = (state_d == BLOCKED) && (state_q != BLOCKED);
  assign stay_blk  = (state_d == BLOCKED) && (state_q == BLOCKED);
  assign block_d   = (state_d == BLOCKED);

  // Entering or remaining in BLOCKED takes priority over a clear pulse.
  always_comb begin
    sticky_d = sticky_q;
    if (enter_blk || stay_blk) sticky_d = 1'b1;
    else if (mon.clear)        sticky_d = 1'b0;
  end

  // NOTE: state flops use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      block_q  <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      block_q  <= block_d;
      sticky_q <= sticky_d;
    end
  end

  assign mon.block        = block_q;
  assign mon.block_sticky = sticky_q;

`ifdef HLS_DEADLOCK_MON_REPORT_EN
  localparam int SRC_W = src_w(NQ);

  logic [SRC_W-1:0] low_idx;
  logic [SRC_W-1:0] src_d, src_q;
  logic [CNT_W-1:0] cyc_d, cyc_q;
  logic             idle_exit;

  hls_deadlock_prio_enc #(
    .W  (NQ),
    .OW (SRC_W)
  ) u_prio_enc (
    .vec (q),
    .idx (low_idx)
  );

  assign idle_exit = (state_q == IDLE) && any_blk;

  // Source is latched only when qualification starts; duration counts
  // the episode and both hold after it ends until cleared.
  always_comb begin
    src_d = src_q;
    cyc_d = cyc_q;
    if (mon.clear && !enter_blk && !stay_blk) begin
      src_d = '0;
      cyc_d = '0;
    end
    if (idle_exit) src_d = low_idx;
    if (enter_blk)     cyc_d = CNT_W'(1);
    else if (stay_blk) cyc_d = CNT_W'(sat_inc(64'(cyc_q), CNT_W));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      src_q <= '0;
      cyc_q <= '0;
    end else begin
      src_q <= src_d;
      cyc_q <= cyc_d;
    end
  end

  assign mon.block_src    = src_q;
  assign mon.block_cycles = cyc_q;
`else
  assign mon.block_src    = '0;
  assign mon.block_cycles = '0;
`endif

endmodule

// File: tb/tb_hls_deadlock_monitor_gen2.sv
// Self-checking bench for hls_deadlock_monitor_gen2: three instances
// (threshold 4, legacy threshold 1, narrow counter) checked by a scoreboard.
module tb_hls_deadlock_monitor_gen2;

`ifdef HLS_DEADLOCK_MON_REPORT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  typedef struct packed {
    int   run;
    logic blk;
    logic sticky;
    int   src;
    int   cyc;
  } model_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hls_deadlock_monitor_gen2_if #(.NUM_AXIS(5), .NUM_SUB(4), .CNT_W(16)) a_if ();
  hls_deadlock_monitor_gen2_if #(.NUM_AXIS(5), .NUM_SUB(0), .CNT_W(16)) b_if ();
  hls_deadlock_monitor_gen2_if #(.NUM_AXIS(2), .NUM_SUB(1), .CNT_W(4))  c_if ();

  hls_deadlock_monitor_gen2 #(.NUM_AXIS(5), .NUM_SUB(4), .THRESHOLD(4), .CNT_W(16))
    u_a (.clock(clk), .reset(rst), .mon(a_if));
  hls_deadlock_monitor_gen2 #(.NUM_AXIS(5), .NUM_SUB(0), .THRESHOLD(1), .CNT_W(16))
    u_b (.clock(clk), .reset(rst), .mon(b_if));
  hls_deadlock_monitor_gen2 #(.NUM_AXIS(2), .NUM_SUB(1), .THRESHOLD(4), .CNT_W(4))
    u_c (.clock(clk), .reset(rst), .mon(c_if));

  int n_tests = 0;
  int n_fail  = 0;
  string cur = "init";

  logic [4:0] a_axis = '0;
  logic [3:0] a_sub  = '0;
  logic [3:0] a_idle = '0;
  logic       a_clr  = 1'b0;
  logic [4:0] b_axis = '0;
  logic [1:0] c_axis = '0;
  logic       c_sub  = 1'b0;
  logic       c_idle = 1'b0;

  model_t ma = '0, mb = '0, mc = '0;
  model_t qa[$], qb[$], qc[$];

  function automatic int lowest(input logic [15:0] v);
    int r;
    r = 0;
    for (int i = 15; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  // Cycle model in run-length terms: block is up once the run of
  // consecutive blocked cycles reaches the threshold.
  function automatic model_t model_step(input model_t m, input logic [15:0] q,
                                        input int thr, input int cw, input logic clr);
    model_t n;
    logic   nb, enter, stay;
    int     maxv;
    n     = m;
    maxv  = (1 << cw) - 1;
    n.run = (q != 0) ? ((m.run < 100000) ? m.run + 1 : m.run) : 0;
    nb    = (n.run >= thr);
    enter = nb && !m.blk;
    stay  = nb && m.blk;
    n.blk = nb;
    if (enter || stay) n.sticky = 1'b1;
    else if (clr)      n.sticky = 1'b0;
    if (clr && !enter && !stay) begin
      n.src = 0;
      n.cyc = 0;
    end
    if (m.run == 0 && q != 0) n.src = lowest(q);
    if (enter) n.cyc = 1;
    else if (stay && m.cyc < maxv) n.cyc = m.cyc + 1;
    return n;
  endfunction

  task automatic step();
    model_t e;
    int     es;
    int     ec;
    a_if.axis_block_sigs = a_axis;
    a_if.sub_block_sigs  = a_sub;
    a_if.inst_idle_sigs  = a_idle;
    a_if.clear           = a_clr;
    b_if.axis_block_sigs = b_axis;
    b_if.sub_block_sigs  = 1'b0;
    b_if.inst_idle_sigs  = 1'b0;
    b_if.clear           = 1'b0;
    c_if.axis_block_sigs = c_axis;
    c_if.sub_block_sigs  = c_sub;
    c_if.inst_idle_sigs  = c_idle;
    c_if.clear           = 1'b0;
    ma = model_step(ma, 16'({a_sub & ~a_idle, a_axis}), 4, 16, a_clr);
    qa.push_back(ma);
    mb = model_step(mb, 16'(b_axis), 1, 16, 1'b0);
    qb.push_back(mb);
    mc = model_step(mc, 16'({c_sub & ~c_idle, c_axis}), 4, 4, 1'b0);
    qc.push_back(mc);
    @(posedge clk);
    @(negedge clk);

    e = qa.pop_front(); es = REP ? e.src : 0; ec = REP ? e.cyc : 0;
    n_tests += 4;
    if (a_if.block !== e.blk) begin
      n_fail++; $display("FAIL %s a.block got %0b want %0b", cur, a_if.block, e.blk);
    end
    if (a_if.block_sticky !== e.sticky) begin
      n_fail++; $display("FAIL %s a.sticky got %0b want %0b", cur, a_if.block_sticky, e.sticky);
    end
    if (a_if.block_src !== 4'(es)) begin
      n_fail++; $display("FAIL %s a.src got %0d want %0d", cur, a_if.block_src, es);
    end
    if (a_if.block_cycles !== 16'(ec)) begin
      n_fail++; $display("FAIL %s a.cycles got %0d want %0d", cur, a_if.block_cycles, ec);
    end

    e = qb.pop_front(); es = REP ? e.src : 0; ec = REP ? e.cyc : 0;
    n_tests += 4;
    if (b_if.block !== e.blk) begin
      n_fail++; $display("FAIL %s b.block got %0b want %0b", cur, b_if.block, e.blk);
    end
    if (b_if.block_sticky !== e.sticky) begin
      n_fail++; $display("FAIL %s b.sticky got %0b want %0b", cur, b_if.block_sticky, e.sticky);
    end
    if (b_if.block_src !== 3'(es)) begin
      n_fail++; $display("FAIL %s b.src got %0d want %0d", cur, b_if.block_src, es);
    end
    if (b_if.block_cycles !== 16'(ec)) begin
      n_fail++; $display("FAIL %s b.cycles got %0d want %0d", cur, b_if.block_cycles, ec);
    end

    e = qc.pop_front(); es = REP ? e.src : 0; ec = REP ? e.cyc : 0;
    n_tests += 4;
    if (c_if.block !== e.blk) begin
      n_fail++; $display("FAIL %s c.block got %0b want %0b", cur, c_if.block, e.blk);
    end
    if (c_if.block_sticky !== e.sticky) begin
      n_fail++; $display("FAIL %s c.sticky got %0b want %0b", cur, c_if.block_sticky, e.sticky);
    end
    if (c_if.block_src !== 2'(es)) begin
      n_fail++; $display("FAIL %s c.src got %0d want %0d", cur, c_if.block_src, es);
    end
    if (c_if.block_cycles !== 4'(ec)) begin
      n_fail++; $display("FAIL %s c.cycles got %0d want %0d", cur, c_if.block_cycles, ec);
    end
  endtask

  task automatic test_reset();
    cur = "reset";
    #1 rst = 1'b1;
    #2;
    n_tests += 6;
    if (a_if.block !== 1'b0 || a_if.block_sticky !== 1'b0) begin
      n_fail++; $display("FAIL reset a.block/sticky got %0b/%0b want 0/0", a_if.block, a_if.block_sticky);
    end
    if (a_if.block_src !== 4'd0 || a_if.block_cycles !== 16'd0) begin
      n_fail++; $display("FAIL reset a.src/cycles got %0d/%0d want 0/0", a_if.block_src, a_if.block_cycles);
    end
    if (b_if.block !== 1'b0 || b_if.block_sticky !== 1'b0) begin
      n_fail++; $display("FAIL reset b.block/sticky got %0b/%0b want 0/0", b_if.block, b_if.block_sticky);
    end
    if (b_if.block_src !== 3'd0 || b_if.block_cycles !== 16'd0) begin
      n_fail++; $display("FAIL reset b.src/cycles got %0d/%0d want 0/0", b_if.block_src, b_if.block_cycles);
    end
    if (c_if.block !== 1'b0 || c_if.block_sticky !== 1'b0) begin
      n_fail++; $display("FAIL reset c.block/sticky got %0b/%0b want 0/0", c_if.block, c_if.block_sticky);
    end
    if (c_if.block_src !== 2'd0 || c_if.block_cycles !== 4'd0) begin
      n_fail++; $display("FAIL reset c.src/cycles got %0d/%0d want 0/0", c_if.block_src, c_if.block_cycles);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_threshold();
    cur = "threshold";
    a_axis = 5'b00010;
    repeat (3) step();
    a_axis = '0;
    step();
    n_tests++;
    if (a_if.block !== 1'b0) begin
      n_fail++; $display("FAIL threshold short_run block got %0b want 0", a_if.block);
    end
    a_axis = 5'b00010;
    repeat (3) step();
    n_tests++;
    if (a_if.block !== 1'b0) begin
      n_fail++; $display("FAIL threshold t+3 block got %0b want 0", a_if.block);
    end
    step();
    n_tests++;
    if (a_if.block !== 1'b1) begin
      n_fail++; $display("FAIL threshold t+4 block got %0b want 1", a_if.block);
    end
    a_axis = '0;
    step();
    n_tests++;
    if (a_if.block !== 1'b0) begin
      n_fail++; $display("FAIL threshold deassert block got %0b want 0", a_if.block);
    end
    a_clr = 1'b1;
    step();
    a_clr = 1'b0;
  endtask

  task automatic test_idle_mask();
    cur = "idle_mask";
    a_sub  = 4'b0100;
    a_idle = 4'b0100;
    repeat (50) step();
    n_tests++;
    if (a_if.block !== 1'b0) begin
      n_fail++; $display("FAIL idle_mask masked block got %0b want 0", a_if.block);
    end
    a_idle = '0;
    repeat (4) step();
    n_tests += 2;
    if (a_if.block !== 1'b1) begin
      n_fail++; $display("FAIL idle_mask unmasked block got %0b want 1", a_if.block);
    end
    if (a_if.block_src !== (REP ? 4'd7 : 4'd0)) begin
      n_fail++; $display("FAIL idle_mask src got %0d want %0d", a_if.block_src, REP ? 7 : 0);
    end
    a_sub = '0;
    step();
    a_clr = 1'b1;
    step();
    a_clr = 1'b0;
  endtask

  task automatic test_duration();
    cur = "duration";
    a_axis = 5'b00001;
    repeat (4 + 9) step();
    a_axis = '0;
    step();
    n_tests += 3;
    if (a_if.block_cycles !== (REP ? 16'd10 : 16'd0)) begin
      n_fail++; $display("FAIL duration cycles got %0d want %0d", a_if.block_cycles, REP ? 10 : 0);
    end
    if (a_if.block_sticky !== 1'b1) begin
      n_fail++; $display("FAIL duration sticky got %0b want 1", a_if.block_sticky);
    end
    if (a_if.block !== 1'b0) begin
      n_fail++; $display("FAIL duration block got %0b want 0", a_if.block);
    end
    a_clr = 1'b1;
    step();
    a_clr = 1'b0;
    n_tests++;
    if (a_if.block_sticky !== 1'b0 || a_if.block_src !== 4'd0 || a_if.block_cycles !== 16'd0) begin
      n_fail++; $display("FAIL duration clear sticky/src/cycles got %0b/%0d/%0d want 0/0/0",
                         a_if.block_sticky, a_if.block_src, a_if.block_cycles);
    end
  endtask

  task automatic test_clear_precedence();
    cur = "clear_prec";
    a_axis = 5'b01000;
    repeat (3) step();
    a_clr = 1'b1;
    step();
    n_tests++;
    if (a_if.block_sticky !== 1'b1 || a_if.block !== 1'b1) begin
      n_fail++; $display("FAIL clear_prec entry sticky/block got %0b/%0b want 1/1",
                         a_if.block_sticky, a_if.block);
    end
    step();
    a_clr = 1'b0;
    n_tests++;
    if (a_if.block_cycles !== (REP ? 16'd2 : 16'd0)) begin
      n_fail++; $display("FAIL clear_prec blocked_cycle cycles got %0d want %0d",
                         a_if.block_cycles, REP ? 2 : 0);
    end
    a_axis = '0;
    step();
  endtask

  task automatic test_legacy();
    logic prev_or;
    cur = "legacy";
    for (int i = 0; i < 200; i++) begin
      b_axis  = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      prev_or = |b_axis;
      step();
      n_tests++;
      if (b_if.block !== prev_or) begin
        n_fail++; $display("FAIL legacy cycle %0d block got %0b want %0b", i, b_if.block, prev_or);
      end
    end
    b_axis = '0;
    step();
  endtask

  task automatic test_async_reset();
    cur = "async_reset";
    a_axis = 5'b01000;
    repeat (2) step();
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (a_if.block !== 1'b0 || a_if.block_sticky !== 1'b0 || a_if.block_src !== 4'd0 ||
        a_if.block_cycles !== 16'd0) begin
      n_fail++; $display("FAIL async_reset suspect outputs got %0b/%0b/%0d/%0d want 0/0/0/0",
                         a_if.block, a_if.block_sticky, a_if.block_src, a_if.block_cycles);
    end
    #1 rst = 1'b0;
    ma = '0; mb = '0; mc = '0;
    repeat (3) step();
    n_tests++;
    if (a_if.block !== 1'b0) begin
      n_fail++; $display("FAIL async_reset requal t+3 block got %0b want 0", a_if.block);
    end
    step();
    n_tests++;
    if (a_if.block !== 1'b1) begin
      n_fail++; $display("FAIL async_reset requal t+4 block got %0b want 1", a_if.block);
    end
    step();
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (a_if.block !== 1'b0 || a_if.block_sticky !== 1'b0 || a_if.block_src !== 4'd0 ||
        a_if.block_cycles !== 16'd0) begin
      n_fail++; $display("FAIL async_reset blocked outputs got %0b/%0b/%0d/%0d want 0/0/0/0",
                         a_if.block, a_if.block_sticky, a_if.block_src, a_if.block_cycles);
    end
    #1 rst = 1'b0;
    ma = '0; mb = '0; mc = '0;
    repeat (3) step();
    n_tests++;
    if (a_if.block !== 1'b0) begin
      n_fail++; $display("FAIL async_reset second requal block got %0b want 0", a_if.block);
    end
    a_axis = '0;
    step();
  endtask

  task automatic test_saturation();
    cur = "saturation";
    c_axis = 2'b01;
    repeat (4 + 13) step();
    n_tests++;
    if (c_if.block_cycles !== (REP ? 4'd14 : 4'd0)) begin
      n_fail++; $display("FAIL saturation pre cycles got %0d want %0d", c_if.block_cycles, REP ? 14 : 0);
    end
    repeat (40 - 13) step();
    n_tests += 2;
    if (c_if.block_cycles !== (REP ? 4'd15 : 4'd0)) begin
      n_fail++; $display("FAIL saturation cycles got %0d want %0d", c_if.block_cycles, REP ? 15 : 0);
    end
    if (c_if.block !== 1'b1) begin
      n_fail++; $display("FAIL saturation block got %0b want 1", c_if.block);
    end
    c_axis = '0;
    step();
  endtask

  initial begin
    test_reset();
    test_threshold();
    test_idle_mask();
    test_duration();
    test_clear_precedence();
    test_legacy();
    test_async_reset();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached in %s", cur);
    $fatal(1, "watchdog");
  end

endmodule
